// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial adder/subtractor, one SLICE-bit slice per clock with a carry register.
// Optional build macro ADDSUB_SEQ_SAT_EN adds a Sat input that clamps signed overflow to the limits.
module addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Sub,
`ifdef ADDSUB_SEQ_SAT_EN
    input  logic             Sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int unsigned SW  = SLICE + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] s_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             cout_q;
    logic             v_q;
    logic             z_q;
    logic             n_q;
`ifdef ADDSUB_SEQ_SAT_EN
    logic             sat_q;
`endif

    logic [SLICE-1:0] xs_c;
    logic [SLICE-1:0] ys_c;
    logic [SW-1:0]    sum_c;
    logic             last_c;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] res_d;
    logic             v_d;

    // Slice datapath: select slice k, add with carry, merge into the partial result.
    always_comb begin
        xs_c = '0;
        ys_c = '0;
        for (int unsigned i = 0; i < NSL; i++) begin
            if (cnt_q == CW'(i)) begin
                xs_c = x_q[i*SLICE +: SLICE];
                ys_c = y_q[i*SLICE +: SLICE];
            end
        end
        sum_c = SW'(xs_c) + SW'(ys_c) + SW'(carry_q);
        s_d   = s_q;
        for (int unsigned i = 0; i < NSL; i++) begin
            if (cnt_q == CW'(i)) begin
                s_d[i*SLICE +: SLICE] = sum_c[SLICE-1:0];
            end
        end
        last_c = (cnt_q == CW'(NSL - 1));
        v_d    = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (s_d[WIDTH-1] != x_q[WIDTH-1]);
        res_d  = s_d;
`ifdef ADDSUB_SEQ_SAT_EN
        if (sat_q && v_d) begin
            res_d = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
`ifdef ADDSUB_SEQ_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= X;
                        y_q        <= Y ^ {WIDTH{Sub}};
                        carry_q    <= Sub;
                        cnt_q      <= '0;
`ifdef ADDSUB_SEQ_SAT_EN
                        sat_q      <= Sat;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= sum_c[SLICE];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_c) begin
                        // Flags report the wrapped result; Z follows the (possibly clamped) S.
                        s_q         <= res_d;
                        cout_q      <= sum_c[SLICE];
                        v_q         <= v_d;
                        z_q         <= (res_d == '0);
                        n_q         <= s_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        s_q <= s_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign Z         = z_q;
    assign N         = n_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: self-checking bench for addsub_seq (32/4 instance plus a 16/16 single-slice instance).
// Compile with ADDSUB_SEQ_SAT_EN defined to exercise saturation.
module tb_addsub_seq;

    localparam int unsigned W   = 32;
    localparam int unsigned SL  = 4;
    localparam int unsigned NSL = W / SL;
`ifdef ADDSUB_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, sub, sat, out_valid, out_ready;
    logic [W-1:0]  x, y, s;
    logic          cout, v, z, n;

    logic          b_in_valid, b_in_ready, b_sub, b_sat, b_out_valid, b_out_ready;
    logic [15:0]   b_x, b_y, b_s;
    logic          b_cout, b_v, b_z, b_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(W), .SLICE(SL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(x), .Y(y), .Sub(sub),
`ifdef ADDSUB_SEQ_SAT_EN
        .Sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .Cout(cout), .V(v), .Z(z), .N(n)
    );

    addsub_seq #(.WIDTH(16), .SLICE(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .X(b_x), .Y(b_y), .Sub(b_sub),
`ifdef ADDSUB_SEQ_SAT_EN
        .Sat(b_sat),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .S(b_s), .Cout(b_cout), .V(b_v), .Z(b_z), .N(b_n)
    );

    // Reference: signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sb,
                                  input logic st, output logic [35:0] exp);
        longint          sr;
        longint unsigned ua, ub;
        logic [31:0]     es;
        logic            ec, ev, en;
        sr = sb ? (longint'($signed(a)) - longint'($signed(b)))
                : (longint'($signed(a)) + longint'($signed(b)));
        ua = 64'(a);
        ub = 64'(b);
        ev = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        ec = sb ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
        es = sb ? (a - b) : (a + b);
        en = es[31];
        if (SAT_EN && st && ev) es = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        exp = {es, ec, ev, (es == 32'h0), en};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'h0000_0000;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h7FFF_FFFF;
            3: pick = 32'h8000_0000;
            default: pick = $urandom;
        endcase
    endfunction

    // Drives one operation through the handshake, holding out_ready low for 'hold' cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sb, input logic st,
                          input int hold, output logic [35:0] got, output int lat);
        x = a; y = b; sub = sb; sat = st; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; x = $urandom; y = $urandom; sub = 1'($urandom); sat = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {s, cout, v, z, n};
        repeat (hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; x = 32'h1234_5678; y = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, s, cout, v, z, n} !== {1'b1, 1'b0, 32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b S=%h CVZN=%b%b%b%b required rdy=1 vld=0 S=0 CVZN=0000",
                     in_ready, out_valid, s, cout, v, z, n);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wins: got in_ready=%b b_in_ready=%b required 1 1", in_ready, b_in_ready);
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        sb, st;
        logic [35:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t        tv[7];
        logic [35:0] got;
        int          lat;
        tv[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0001_0000, 4'b0000}};
        tv[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, {32'hFFFF_FFFE, 4'b0001}};
        tv[2] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, {32'h0000_0000, 4'b1010}};
        tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 4'b0101}};
        tv[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1,
                  {(SAT_EN ? 32'h7FFF_FFFF : 32'h8000_0000), 4'b0101}};
        tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
                  {(SAT_EN ? 32'h8000_0000 : 32'h7FFF_FFFF), 4'b1100}};
        tv[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, {32'h0000_0000, 4'b1010}};
        for (int i = 0; i < 7; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].sb, tv[i].st, i % 3, got, lat);
            checks++;
            if (lat != int'(NSL)) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, NSL);
            end
            checks++;
            if (got !== tv[i].exp) begin
                errors++;
                $display("FAIL directed_result[%0d]: got S=%h CVZN=%b required S=%h CVZN=%b",
                         i, got[35:4], got[3:0], tv[i].exp[35:4], tv[i].exp[3:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        sb, st;
        logic [35:0] got, exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = pick(); b = pick(); sb = 1'($urandom); st = 1'($urandom);
            model(a, b, sb, st, exp);
            run_op(a, b, sb, st, $urandom_range(0, 3), got, lat);
            checks++;
            if (lat != int'(NSL) || got !== exp) begin
                errors++;
                $display("FAIL random[%0d] %h %s %h sat=%b: got lat=%0d S=%h CVZN=%b required lat=%0d S=%h CVZN=%b",
                         i, a, sb ? "-" : "+", b, st, lat, got[35:4], got[3:0], NSL, exp[35:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp;
        int          lat;
        model(32'h0123_4567, 32'h0FED_CBA9, 1'b0, 1'b0, exp);
        x = 32'h0123_4567; y = 32'h0FED_CBA9; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x = $urandom; y = $urandom; sub = 1'($urandom);
            checks++;
            if ({out_valid, in_ready, s, cout, v, z, n} !== {2'b10, exp}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b S=%h CVZN=%b%b%b%b required vld=1 rdy=0 S=%h CVZN=%b",
                         i, out_valid, in_ready, s, cout, v, z, n, exp[35:4], exp[3:0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, s} !== {2'b01, exp[35:4]}) begin
            errors++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b S=%h required vld=0 rdy=1 S=%h",
                     out_valid, in_ready, s, exp[35:4]);
        end
    endtask

    task automatic test_rst_abort();
        logic [35:0] got;
        int          lat;
        logic        seen;
        x = 32'h1111_1111; y = 32'h2222_2222; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, s, cout, v, z, n} !== {1'b1, 1'b0, 32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL rst_abort_values: got rdy=%b vld=%b S=%h CVZN=%b%b%b%b required rdy=1 vld=0 S=0 CVZN=0000",
                     in_ready, out_valid, s, cout, v, z, n);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort_no_result: got out_valid seen=%b required 0", seen);
        end
        run_op(32'h1, 32'h2, 1'b0, 1'b0, 0, got, lat);
        checks++;
        if (lat != int'(NSL) || got !== {32'h3, 4'b0000}) begin
            errors++;
            $display("FAIL rst_abort_followup: got lat=%0d S=%h CVZN=%b required lat=%0d S=00000003 CVZN=0000",
                     lat, got[35:4], got[3:0], NSL);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] expq[$];
        logic [35:0] exp;
        int          last_acc, n_res, cyc;
        logic        acc;
        last_acc = -1; n_res = 0; cyc = 0;
        out_ready = 1'b1; sat = 1'b0; x = $urandom; y = $urandom; sub = 1'($urandom); in_valid = 1'b1;
        while (n_res < 4 && cyc < 200) begin
            acc = in_ready;
            if (out_valid) begin
                checks++;
                if (expq.size() == 0 || {s, cout, v, z, n} !== expq[0]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got S=%h CVZN=%b%b%b%b required %h",
                             n_res, s, cout, v, z, n, (expq.size() == 0) ? 36'h0 : expq[0]);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                n_res++;
            end
            if (acc) begin
                model(x, y, sub, 1'b0, exp);
                expq.push_back(exp);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != int'(NSL) + 2) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d cycles required %0d", cyc - last_acc, NSL + 2);
                    end
                end
                last_acc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                x = $urandom; y = $urandom; sub = 1'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (n_res != 4) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results required 4", n_res);
        end
    endtask

    task automatic test_single_slice();
        logic [15:0] a, b, es;
        logic        sb, st, ec, ev, en;
        int          sr, lat;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                a = 16'hFFFF; b = 16'h0001; sb = 1'b0; st = 1'b0;
            end else begin
                a = 16'($urandom); b = 16'($urandom); sb = 1'($urandom); st = 1'($urandom);
            end
            sr = sb ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
            ev = (sr > 32767) || (sr < -32768);
            ec = sb ? (a >= b) : ((int'(a) + int'(b)) > 65535);
            es = sb ? (a - b) : (a + b);
            en = es[15];
            if (SAT_EN && st && ev) es = a[15] ? 16'h8000 : 16'h7FFF;
            b_x = a; b_y = b; b_sub = sb; b_sat = st; b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            lat = 0;
            while (!b_out_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat != 1 || {b_s, b_cout, b_v, b_z, b_n} !== {es, ec, ev, (es == 16'h0), en}) begin
                errors++;
                $display("FAIL single_slice[%0d] %h %s %h: got lat=%0d S=%h CVZN=%b%b%b%b required lat=1 S=%h CVZN=%b%b%b%b",
                         i, a, sb ? "-" : "+", b, lat, b_s, b_cout, b_v, b_z, b_n, es, ec, ev, (es == 16'h0), en);
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; sat = 1'b0; x = '0; y = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_sub = 1'b0; b_sat = 1'b0; b_x = '0; b_y = '0;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_rst_abort();
        test_back_to_back();
        test_single_slice();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
